// File: rtl/fp_mul_pipe.sv
// Four-stage pipelined floating-point multiplier {sign, exp, mantissa} with a global-stall handshake.
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_mul_pipe #(
  parameter  int unsigned EXP_W = 7,
  parameter  int unsigned MAN_W = 16,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] float_a,
  input  logic [W-1:0] float_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] float_out,
  output logic         float_out_overflow,
  output logic         float_out_underflow
);

  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned PW   = 2 * MAN_W + 2;
  localparam int unsigned BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (2 ** EXP_W) - 1;
`ifdef FP_MUL_ROUND_NEAREST_EN
  localparam int unsigned MW1  = MAN_W + 1;
`endif

  logic stall;

  // The whole pipe freezes while the output holds an unaccepted result.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic             s1_v, s1_s;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W-1:0] s1_ma, s1_mb;

  logic                 s2_v, s2_s, s2_zero;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;

  logic         s3_v, s3_ovf, s3_unf;
  logic [W-1:0] s3_res;

  logic [PW-1:0]        norm;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]     mant, mant_f;
  logic [W-1:0]         res;
  logic                 ovf, unf;
  logic                 unused_norm;
`ifdef FP_MUL_ROUND_NEAREST_EN
  logic             guard, sticky, round_up;
  logic [MAN_W:0]   mant_r;
`endif

  // S3 combinational: normalise, optional rounding, then classify the exponent.
  always_comb begin
    norm   = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    exp_n  = s2_exp + (s2_prod[PW-1] ? EW'(1) : EW'(0));
    mant   = norm[PW-2 -: MAN_W];
`ifdef FP_MUL_ROUND_NEAREST_EN
    guard       = norm[MAN_W];
    sticky      = |norm[MAN_W-1:0];
    round_up    = guard & (sticky | mant[0]);
    mant_r      = {1'b0, mant} + MW1'(round_up);
    exp_r       = exp_n + EW'(mant_r[MAN_W]);
    mant_f      = mant_r[MAN_W-1:0];
    unused_norm = norm[PW-1];
`else
    exp_r       = exp_n;
    mant_f      = mant;
    unused_norm = ^{norm[PW-1], norm[MAN_W:0]};
`endif
    ovf = 1'b0;
    unf = 1'b0;
    res = {s2_s, exp_r[EXP_W-1:0], mant_f};
    if (s2_zero) begin
      res = {s2_s, {(W-1){1'b0}}};
    end else if (exp_r > $signed(EW'(EMAX))) begin
      ovf = 1'b1;
      res = {s2_s, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
    end else if (exp_r < $signed(EW'(1))) begin
      unf = 1'b1;
      res = {s2_s, {(W-1){1'b0}}};
    end
  end

  // Pipeline registers; every stage holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v                <= 1'b0;
      s1_s                <= 1'b0;
      s1_ea               <= '0;
      s1_eb               <= '0;
      s1_ma               <= '0;
      s1_mb               <= '0;
      s2_v                <= 1'b0;
      s2_s                <= 1'b0;
      s2_zero             <= 1'b0;
      s2_exp              <= '0;
      s2_prod             <= '0;
      s3_v                <= 1'b0;
      s3_ovf              <= 1'b0;
      s3_unf              <= 1'b0;
      s3_res              <= '0;
      out_valid           <= 1'b0;
      float_out           <= '0;
      float_out_overflow  <= 1'b0;
      float_out_underflow <= 1'b0;
    end else if (!stall) begin
      s1_v  <= in_valid;
      s1_s  <= float_a[W-1] ^ float_b[W-1];
      s1_ea <= float_a[W-2 -: EXP_W];
      s1_eb <= float_b[W-2 -: EXP_W];
      s1_ma <= float_a[MAN_W-1:0];
      s1_mb <= float_b[MAN_W-1:0];

      s2_v    <= s1_v;
      s2_s    <= s1_s;
      s2_zero <= (s1_ea == '0) | (s1_eb == '0);
      s2_exp  <= EW'(s1_ea) + EW'(s1_eb) - EW'(BIAS);
      s2_prod <= PW'({1'b1, s1_ma}) * PW'({1'b1, s1_mb});

      // Flags are gated by valid so bubbles never carry a stale flag.
      s3_v   <= s2_v;
      s3_ovf <= s2_v & ovf;
      s3_unf <= s2_v & unf;
      s3_res <= res;

      out_valid           <= s3_v;
      float_out           <= s3_res;
      float_out_overflow  <= s3_ovf;
      float_out_underflow <= s3_unf;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: driver pushes model results, a monitor pops on each output transfer.
module tb_fp_mul_pipe;

  localparam int unsigned EXP_W = 7;
  localparam int unsigned MAN_W = 16;
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int          BIAS  = 63;
  localparam int          EMAX  = 127;

  typedef struct {
    logic [W+1:0] val;   // {ovf, unf, word}
    int           cyc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] float_a = '0;
  logic [W-1:0] float_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] float_out;
  logic         float_out_overflow;
  logic         float_out_underflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
  exp_t sb[$];

  bit           prev_stall = 1'b0;
  logic [W+1:0] prev_o = '0;

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .float_a             (float_a),
    .float_b             (float_b),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .float_out           (float_out),
    .float_out_overflow  (float_out_overflow),
    .float_out_underflow (float_out_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input longint act, input longint req);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: exact significand product, then round by comparing the discarded remainder to one half.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int     ea, eb, e, sh;
    longint p, q;
    logic   s;
`ifdef FP_MUL_ROUND_NEAREST_EN
    longint rem, half;
`endif
    ea = int'(a[W-2 -: EXP_W]);
    eb = int'(b[W-2 -: EXP_W]);
    s  = a[W-1] ^ b[W-1];
    if (ea == 0 || eb == 0) return {2'b00, s, {(W-1){1'b0}}};
    p = (longint'(a[MAN_W-1:0]) + (longint'(1) << MAN_W)) *
        (longint'(b[MAN_W-1:0]) + (longint'(1) << MAN_W));
    e = ea + eb - BIAS;
    if (p >= (longint'(1) << (2 * MAN_W + 1))) begin
      sh = MAN_W + 1;
      e  = e + 1;
    end else begin
      sh = MAN_W;
    end
    q = p >> sh;
`ifdef FP_MUL_ROUND_NEAREST_EN
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == (longint'(1) << (MAN_W + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
`endif
    if (e > EMAX) return {2'b10, s, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
    if (e < 1)    return {2'b01, s, {(W-1){1'b0}}};
    return {2'b00, s, EXP_W'(e), MAN_W'(q)};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0)     e = '0;
    else if (k < 4) e = EXP_W'($urandom_range(1, EMAX));
    else            e = EXP_W'($urandom_range(45, 81));
    m = MAN_W'($urandom);
    if ($urandom_range(0, 7) == 0) m = '1;
    return {1'($urandom), e, m};
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W+1:0] ev, input bit lat);
    int   n;
    bit   acc;
    exp_t x;
    n   = 0;
    acc = 1'b0;
    float_a  = a;
    float_b  = b;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (acc) begin
      x.val = ev;
      x.cyc = cyc;
      x.lat = lat;
      sb.push_back(x);
    end else begin
      chk(1'b0, "accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] a, input logic [W-1:0] b, input bit lat);
    send(a, b, model(a, b), lat);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single driver of out_ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on each output transfer.
  initial begin
    exp_t e;
    logic [W+1:0] o;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
        continue;
      end
      o = {float_out_overflow, float_out_underflow, float_out};
      chk(in_ready == !(out_valid && !out_ready), "in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (!out_valid)
        chk(!float_out_overflow && !float_out_underflow, "flags_idle", longint'(o[W+1:W]), 0);
      else
        chk(!(float_out_overflow && float_out_underflow), "flags_exclusive", longint'(o[W+1:W]), 0);
      if (prev_stall)
        chk(out_valid && o == prev_o, "stall_stable", longint'({out_valid, o}), longint'({1'b1, prev_o}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_output", longint'(o), 0);
        end else begin
          e = sb.pop_front();
          chk(o == e.val, "result", longint'(o), longint'(e.val));
          if (e.lat) chk(cyc - e.cyc == 4, "latency", longint'(cyc - e.cyc), 4);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_o     = o;
    end
  end

  initial begin
    int n;
    #1 rst = 1'b0;
    #1;
    chk(out_valid == 1'b0, "reset_out_valid", longint'(out_valid), 0);
    chk(float_out == '0, "reset_float_out", longint'(float_out), 0);
    chk(!float_out_overflow && !float_out_underflow, "reset_flags",
        longint'({float_out_overflow, float_out_underflow}), 0);
    chk(in_ready == 1'b1, "reset_in_ready", longint'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Directed vectors, back-to-back with out_ready high.
    send(24'h3F8000, 24'h3F8000, {2'b00, 24'h402000}, 1'b1);
    idle(6);
    send(24'h3F8000, 24'hC00000, {2'b00, 24'hC08000}, 1'b1);
    for (int i = 0; i < 7; i++) send_model(rnd_op(), rnd_op(), 1'b1);
    send(24'h7F0000, 24'h7F0000, {2'b10, 24'h7FFFFF}, 1'b1);
    send(24'h010000, 24'h810000, {2'b01, 24'h800000}, 1'b1);
    send(24'h000000, 24'h3F8000, {2'b00, 24'h000000}, 1'b1);
`ifdef FP_MUL_ROUND_NEAREST_EN
    send(24'h3F0001, 24'h3F8000, {2'b00, 24'h3F8002}, 1'b1);
`else
    send(24'h3F0001, 24'h3F8000, {2'b00, 24'h3F8001}, 1'b1);
`endif
    send_model(24'h5FFFFF, 24'h3FFFFF, 1'b1);
    send_model(24'h3FFFFF, 24'h3F0001, 1'b1);
    idle(8);

    // Backpressure: hold the consumer off while inputs keep streaming.
    rdy_mode = 2;
    fork
      begin
        for (int i = 0; i < 10; i++) send_model(rnd_op(), rnd_op(), 1'b0);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 50);
        chk(in_ready == 1'b0, "in_ready_fall", longint'(in_ready), 0);
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    idle(8);

    // Random operands and random consumer readiness.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_model(rnd_op(), rnd_op(), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rdy_mode = 0;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size() == 0, "drain", longint'(sb.size()), 0);
    idle(2);

    // Reset with three operations in flight and the head stalled at the output.
    rdy_mode = 2;
    idle(1);
    for (int i = 0; i < 3; i++) send_model(rnd_op(), rnd_op(), 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk(out_valid == 1'b0, "midreset_out_valid", longint'(out_valid), 0);
    chk(!float_out_overflow && !float_out_underflow, "midreset_flags",
        longint'({float_out_overflow, float_out_underflow}), 0);
    chk(in_ready == 1'b1, "midreset_in_ready", longint'(in_ready), 1);
    sb.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk(out_valid == 1'b0, "stale_after_reset", longint'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(24'h3F8000, 24'h3F8000, {2'b00, 24'h402000}, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size() == 0, "final_drain", longint'(sb.size()), 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
